key_code_tone_gen: RTL and testbench

- Receiving end of the song players' `key_code` stream.
- Consumes the 8-bit scan-code note stream (note codes, `8'hf0` = release), glitch-filters it, and maps each accepted note to a half-period divisor.
- Generates a square-wave `audio_out` for the speaker/codec pin.
- Sits between the selected song module (or a live PS/2 decoder) and the audio output pin.

---
 rtl/key_code_tone_gen.sv | 155 +++++++++++++++
 tb/tb_key_code_tone_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_code_tone_gen.sv
// Glitch-filtered scan-code to square-wave tone generator.
// Optional build macro NOTE_COUNT_EN adds the saturating note_count output.
module key_code_tone_gen #(
  parameter int STABLE_CYC = 4,
  parameter int DIV_SHIFT  = 0
) (
  input  logic        clock,
  input  logic        k_tr,
  input  logic [7:0]  key_code,
  output logic        audio_out,
  output logic        note_active,
  output logic [3:0]  note_idx,
  output logic        note_on
`ifdef NOTE_COUNT_EN
  ,
  output logic [15:0] note_count
`endif
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t      r_state;
  logic [7:0]  r_cand;
  logic [7:0]  r_cnt;
  logic [16:0] r_phase;
  logic [16:0] r_div_m1;
  logic        r_audio;
  logic        r_active;
  logic [3:0]  r_note_idx;
  logic        r_note_on;

  logic [16:0] w_tab_div;
  logic [3:0]  w_tab_idx;
  logic [16:0] w_eff_m1;
  logic        w_accept;
  logic        w_start;
  logic        w_stop;

  // Scan-code to divisor / note index lookup on the raw sample.
  always_comb begin
    w_tab_div = 17'd0;
    w_tab_idx = 4'd0;
    case (key_code)
      8'h2b:   begin w_tab_div = 17'd95556; w_tab_idx = 4'd1; end
      8'h34:   begin w_tab_div = 17'd85131; w_tab_idx = 4'd2; end
      8'h33:   begin w_tab_div = 17'd75843; w_tab_idx = 4'd3; end
      8'h3b:   begin w_tab_div = 17'd71586; w_tab_idx = 4'd4; end
      8'h42:   begin w_tab_div = 17'd63776; w_tab_idx = 4'd5; end
      8'h4b:   begin w_tab_div = 17'd56818; w_tab_idx = 4'd6; end
      8'h4c:   begin w_tab_div = 17'd50619; w_tab_idx = 4'd7; end
      8'h52:   begin w_tab_div = 17'd47778; w_tab_idx = 4'd8; end
      default: begin w_tab_div = 17'd0;     w_tab_idx = 4'd0; end
    endcase
  end

  assign w_eff_m1 = (w_tab_div >> DIV_SHIFT) - 17'd1;

  // Acceptance fires once per stable run, on the edge the run length hits STABLE_CYC.
  always_comb begin
    w_accept = 1'b0;
    if (key_code != r_cand) begin
      w_accept = (STABLE_MAX == 8'd1);
    end else begin
      w_accept = (r_cnt == STABLE_MAX - 8'd1);
    end
  end

  // A re-accepted copy of the playing note (e.g. after a rejected glitch) must not retrigger.
  assign w_start = w_accept && (w_tab_idx != 4'd0) &&
                   !((r_state == PLAY) && (r_note_idx == w_tab_idx));
  assign w_stop  = w_accept && (w_tab_idx == 4'd0) && (r_state == PLAY);

  // Glitch filter: candidate code and its run-length counter.
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      r_cand <= 8'hf0;
      r_cnt  <= 8'd0;
    end else if (key_code != r_cand) begin
      r_cand <= key_code;
      r_cnt  <= 8'd1;
    end else if (r_cnt != STABLE_MAX) begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Tone state machine with registered outputs.
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      r_state    <= IDLE;
      r_phase    <= 17'd0;
      r_div_m1   <= 17'd0;
      r_audio    <= 1'b0;
      r_active   <= 1'b0;
      r_note_idx <= 4'd0;
      r_note_on  <= 1'b0;
    end else begin
      r_note_on <= 1'b0;
      if (w_start) begin
        r_state    <= PLAY;
        r_phase    <= w_eff_m1;
        r_div_m1   <= w_eff_m1;
        r_audio    <= 1'b1;
        r_active   <= 1'b1;
        r_note_idx <= w_tab_idx;
        r_note_on  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_audio <= 1'b0;
          end
          PLAY: begin
            if (w_stop) begin
              r_state    <= IDLE;
              r_phase    <= 17'd0;
              r_audio    <= 1'b0;
              r_active   <= 1'b0;
              r_note_idx <= 4'd0;
            end else if (r_phase == 17'd0) begin
              r_audio <= ~r_audio;
              r_phase <= r_div_m1;
            end else begin
              r_phase <= r_phase - 17'd1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef NOTE_COUNT_EN
  logic [15:0] r_note_count;

  // Saturating count of note starts.
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      r_note_count <= 16'd0;
    end else if (r_note_on && (r_note_count != 16'hffff)) begin
      r_note_count <= r_note_count + 16'd1;
    end
  end

  assign note_count = r_note_count;
`endif

  assign audio_out   = r_audio;
  assign note_active = r_active;
  assign note_idx    = r_note_idx;
  assign note_on     = r_note_on;

endmodule

// File: tb/tb_key_code_tone_gen.sv
// Randomized bench for key_code_tone_gen against a time-based reference model.
module tb_key_code_tone_gen;

  localparam int SC    = 4;
  localparam int SHIFT = 3;

  logic        clock;
  logic        k_tr;
  logic [7:0]  key_code;
  logic        audio_out;
  logic        note_active;
  logic [3:0]  note_idx;
  logic        note_on;
`ifdef NOTE_COUNT_EN
  logic [15:0] note_count;
`endif

  key_code_tone_gen #(.STABLE_CYC(SC), .DIV_SHIFT(SHIFT)) dut (
    .clock       (clock),
    .k_tr        (k_tr),
    .key_code    (key_code),
    .audio_out   (audio_out),
    .note_active (note_active),
    .note_idx    (note_idx),
    .note_on     (note_on)
`ifdef NOTE_COUNT_EN
    ,
    .note_count  (note_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  note_codes [8] = '{8'h2b, 8'h34, 8'h33, 8'h3b, 8'h42, 8'h4b, 8'h4c, 8'h52};
  int unsigned note_divs  [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  // reference model: run length of identical samples and start time of the current note
  logic [7:0] m_last;
  int         m_run;
  bit         m_play;
  int         m_idx;
  longint     m_div;
  longint     m_t0;
  longint     m_cyc;
  bit         m_on;
  int         m_cnt;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int note_of(input logic [7:0] code);
    for (int i = 0; i < 8; i++) begin
      if (note_codes[i] == code) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_last = 8'hf0;
    m_run  = 0;
    m_play = 1'b0;
    m_idx  = 0;
    m_div  = 1;
    m_t0   = 0;
    m_on   = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_edge(input logic [7:0] s);
    int i;
    m_cyc++;
    if (m_on && m_cnt < 65535) m_cnt++;
    m_on = 1'b0;
    if (s == m_last) m_run++;
    else begin
      m_last = s;
      m_run  = 1;
    end
    if (m_run == SC) begin
      i = note_of(s);
      if (i != 0) begin
        if (!(m_play && m_idx == i)) begin
          m_play = 1'b1;
          m_idx  = i;
          m_div  = longint'(note_divs[i-1] >> SHIFT);
          m_t0   = m_cyc;
          m_on   = 1'b1;
        end
      end else begin
        m_play = 1'b0;
        m_idx  = 0;
      end
    end
  endtask

  function automatic int exp_audio();
    if (!m_play) return 0;
    return (((m_cyc - m_t0) / m_div) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic compare_all();
    check_val("audio_out", longint'(audio_out), longint'(exp_audio()));
    check_val("note_active", longint'(note_active), longint'(m_play));
    check_val("note_idx", longint'(note_idx), longint'(m_idx));
    check_val("note_on", longint'(note_on), longint'(m_on));
`ifdef NOTE_COUNT_EN
    check_val("note_count", longint'(note_count), longint'(m_cnt));
`endif
  endtask

  // one clock: drive at negedge, model on posedge, compare at next negedge
  task automatic cyc(input logic [7:0] code);
    key_code = code;
    @(posedge clock);
    model_edge(code);
    @(negedge clock);
    compare_all();
  endtask

  // asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic apply_reset(input logic [7:0] code);
    #2;
    k_tr     = 1'b0;
    key_code = code;
    #1;
    check_val("rst_audio", longint'(audio_out), 0);
    check_val("rst_active", longint'(note_active), 0);
    check_val("rst_idx", longint'(note_idx), 0);
    check_val("rst_on", longint'(note_on), 0);
`ifdef NOTE_COUNT_EN
    check_val("rst_count", longint'(note_count), 0);
`endif
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    k_tr = 1'b1;
  endtask

  initial begin
    int on_at;
    int fall_at;
    int pulses;
    int r;
    int len;
    logic [7:0] code;

    k_tr     = 1'b0;
    key_code = 8'h4b;
    m_cyc    = 0;
    model_reset();
    @(negedge clock);
    apply_reset(8'h4b);

    // reset and idle
    repeat (1000) cyc(8'hf0);

    // basic note: 4b from the first edge, accepted on edge 4, half period 7102
    on_at   = -1;
    fall_at = -1;
    pulses  = 0;
    for (int j = 1; j <= 14300; j++) begin
      cyc(8'h4b);
      if (note_on) pulses++;
      if (note_on && on_at < 0) on_at = j;
      if (on_at >= 0 && !audio_out && fall_at < 0) fall_at = j;
    end
    check_val("basic_accept_edge", on_at, 4);
    check_val("basic_first_toggle", fall_at - on_at, 7102);
    check_val("basic_pulses", pulses, 1);

    // glitch rejection
    repeat (200) cyc(8'h2b);
    pulses = 0;
    repeat (3) cyc(8'h34);
    for (int j = 0; j < 200; j++) begin
      cyc(8'h2b);
      if (note_on) pulses++;
    end
    check_val("glitch_pulses", pulses, 0);
    check_val("glitch_idx", longint'(note_idx), 1);

    // release and re-press
    pulses = 0;
    for (int j = 0; j < 50; j++) begin cyc(8'h42); if (note_on) pulses++; end
    repeat (10) cyc(8'hf0);
    check_val("release_idx", longint'(note_idx), 0);
    check_val("release_audio", longint'(audio_out), 0);
    for (int j = 0; j < 50; j++) begin cyc(8'h42); if (note_on) pulses++; end
    check_val("repress_pulses", pulses, 2);
    check_val("repress_idx", longint'(note_idx), 5);

    // reset mid-note while audio is high
    repeat (20) cyc(8'h3b);
    check_val("midnote_audio_hi", longint'(audio_out), 1);
    apply_reset(8'h3b);

    // unknown code silences; three note starts
    repeat (10) cyc(8'hf0);
    repeat (30) cyc(8'h2b);
    repeat (30) cyc(8'h33);
    repeat (30) cyc(8'h99);
    check_val("unknown_idx", longint'(note_idx), 0);
    check_val("unknown_active", longint'(note_active), 0);
    repeat (30) cyc(8'h52);
    check_val("last_idx", longint'(note_idx), 8);
`ifdef NOTE_COUNT_EN
    check_val("count_three", longint'(note_count), 3);
`endif

    // randomized runs, including sub-threshold glitches and occasional resets
    repeat (250) begin
      r = $urandom_range(0, 9);
      if (r < 8) code = note_codes[r];
      else if (r == 8) code = 8'hf0;
      else code = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, SC - 1);
      else len = $urandom_range(SC, 60);
      repeat (len) cyc(code);
      if ($urandom_range(0, 40) == 0) apply_reset(code);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
